// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//
// Byte-stream programmer for instr_mem. It drives the writer side of the
// memory port (we/waddr/wdata) from a framed byte stream:
//   [start address] [word count - 1] [word bytes, LSB first] ...
// Each assembled instruction word becomes one single-cycle write at
// sequential, wrapping addresses. busy is high for the whole frame so cores
// can be held off fetching.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the last word. It must equal the
//   XOR of every earlier byte of the frame. A mismatch sets err, which stays
//   set until the next frame's address byte is accepted. Writes that have
//   already been issued are not undone.
//   When undefined, there is no checksum byte and err is tied low.
//
// Parameters:
//   PC_WIDTH    - width of waddr; addresses wrap modulo 2^PC_WIDTH
//   INSTR_WIDTH - instruction width (1..32); ceil(INSTR_WIDTH/8) bytes/word
//
// Ports:
//   clk      - clock, all logic on the rising edge
//   rst_n    - synchronous active-low reset; aborts any frame in progress
//   in_valid - stream byte valid
//   in_data  - stream byte
//   in_ready - loader can accept; a byte transfers when in_valid && in_ready
//   we       - instr_mem write enable (one cycle per word)
//   waddr    - instr_mem write address (holds after we drops)
//   wdata    - instr_mem write data (holds after we drops)
//   busy     - high while a frame is in progress
//   done     - one-cycle pulse at the end of a frame
//   err      - checksum mismatch flag
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int PC_WIDTH    = 4,
    parameter int INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   we,
    output logic [PC_WIDTH-1:0]    waddr,
    output logic [INSTR_WIDTH-1:0] wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int NB   = (INSTR_WIDTH + 7) / 8;
    localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [BI_W-1:0]     LAST_IDX = BI_W'(NB - 1);
    localparam logic [BI_W-1:0]     IDX_ONE  = BI_W'(1);
    localparam logic [PC_WIDTH-1:0] ADDR_ONE = PC_WIDTH'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd5;
`endif

    logic [2:0]          state_r;
    logic [2:0]          next_state_s;
    logic [PC_WIDTH-1:0] addr_r;
    logic [7:0]          remaining_r;
    logic [BI_W-1:0]     byte_idx_r;
    logic [NB*8-1:0]     word_r;
    logic [NB*8-1:0]     word_next_s;
    logic                accept_s;
    logic                ready_next_s;

    assign accept_s = in_valid && in_ready;

    // Next-state decode; in_ready is registered from the upcoming state so it
    // is a clean flop output yet still matches the state it describes.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    next_state_s = S_COUNT;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_COUNT: begin
                if (accept_s) begin
                    next_state_s = S_DATA;
                end else begin
                    next_state_s = S_COUNT;
                end
            end
            S_DATA: begin
                if (accept_s && (byte_idx_r == LAST_IDX)) begin
                    next_state_s = S_WRITE;
                end else begin
                    next_state_s = S_DATA;
                end
            end
            S_WRITE: begin
                if (remaining_r == 8'd0) begin
`ifdef LOADER_CHECKSUM_EN
                    next_state_s = S_CHECK;
`else
                    next_state_s = S_END;
`endif
                end else begin
                    next_state_s = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept_s) begin
                    next_state_s = S_END;
                end else begin
                    next_state_s = S_CHECK;
                end
            end
`endif
            S_END: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Ready decode of the upcoming state: only WRITE and END stall the source.
    always_comb begin
        if ((next_state_s == S_WRITE) || (next_state_s == S_END)) begin
            ready_next_s = 1'b0;
        end else begin
            ready_next_s = 1'b1;
        end
    end

    // Word assembly: the current byte lands in its lane on top of the bytes
    // already collected. Lanes above INSTR_WIDTH are dropped at wdata.
    always_comb begin
        word_next_s = word_r;
        for (int b = 0; b < NB; b++) begin
            if (byte_idx_r == BI_W'(b)) begin
                word_next_s[8*b +: 8] = in_data;
            end else begin
                word_next_s[8*b +: 8] = word_r[8*b +: 8];
            end
        end
    end

    // Main FSM and datapath registers, including the memory write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            addr_r      <= '0;
            remaining_r <= 8'd0;
            byte_idx_r  <= '0;
            word_r      <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            we          <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
        end else begin
            state_r  <= next_state_s;
            in_ready <= ready_next_s;
            busy     <= (next_state_s != S_IDLE);
            done     <= (state_r == S_END);
            we       <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        addr_r <= PC_WIDTH'(in_data);
                    end
                end
                S_COUNT: begin
                    if (accept_s) begin
                        remaining_r <= in_data;
                        byte_idx_r  <= '0;
                    end
                end
                S_DATA: begin
                    if (accept_s) begin
                        word_r <= word_next_s;
                        if (byte_idx_r == LAST_IDX) begin
                            we    <= 1'b1;
                            waddr <= addr_r;
                            wdata <= word_next_s[INSTR_WIDTH-1:0];
                        end else begin
                            byte_idx_r <= byte_idx_r + IDX_ONE;
                        end
                    end
                end
                S_WRITE: begin
                    addr_r     <= addr_r + ADDR_ONE;
                    byte_idx_r <= '0;
                    if (remaining_r != 8'd0) begin
                        remaining_r <= remaining_r - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_r;

    // Running frame checksum: plain XOR over every accepted byte.
    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Checksum accumulation and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_r <= 8'd0;
            err    <= 1'b0;
        end else if (accept_s) begin
            case (state_r)
                S_IDLE: begin
                    csum_r <= in_data;
                    err    <= 1'b0;
                end
                S_CHECK: begin
                    err <= (in_data != csum_r);
                end
                default: begin
                    csum_r <= csum_fold(csum_r, in_data);
                end
            endcase
        end else begin
            csum_r <= csum_r;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v0, v1;
    logic [7:0]  d0, d1;
    logic        r0, we0, busy0, done0, err0;
    logic [3:0]  wa0;
    logic [7:0]  wd0;
    logic        r1, we1, busy1, done1, err1;
    logic [3:0]  wa1;
    logic [11:0] wd1;

    instr_mem_loader #(.PC_WIDTH(4), .INSTR_WIDTH(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0), .in_ready(r0),
        .we(we0), .waddr(wa0), .wdata(wd0), .busy(busy0), .done(done0), .err(err0)
    );

    instr_mem_loader #(.PC_WIDTH(4), .INSTR_WIDTH(12)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_ready(r1),
        .we(we1), .waddr(wa1), .wdata(wd1), .busy(busy1), .done(done1), .err(err1)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       m0, m1;
    logic [7:0] stim[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_we0 = 0;
    int         last_we1 = 0;
    logic       we0_prev = 1'b0;
    logic       we1_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the 8-bit loader: every write pops one expected entry.
    always @(negedge clk) begin
        if (we0 === 1'b1) begin
            checks++;
            assert (we0_prev === 1'b0) else begin
                errors++; $error("FAIL w0_single_cycle observed=%b expected=0", we0_prev);
            end
            checks++;
            assert (busy0 === 1'b1) else begin
                errors++; $error("FAIL w0_busy observed=%b expected=1", busy0);
            end
            checks++;
            assert (q0.size() > 0) else begin
                errors++; $error("FAIL w0_unexpected observed=(%0d,%h) expected=none", wa0, wd0);
            end
            if (q0.size() > 0) begin
                m0 = q0.pop_front();
                checks++;
                assert ({wa0, wd0} === {m0.addr, m0.data[7:0]}) else begin
                    errors++; $error("FAIL w0_write observed=(%0d,%h) expected=(%0d,%h)",
                                     wa0, wd0, m0.addr, m0.data[7:0]);
                end
            end
            last_we0 = cyc;
        end
        we0_prev = we0;
    end

    // Scoreboard for the 12-bit loader.
    always @(negedge clk) begin
        if (we1 === 1'b1) begin
            checks++;
            assert (we1_prev === 1'b0) else begin
                errors++; $error("FAIL w1_single_cycle observed=%b expected=0", we1_prev);
            end
            checks++;
            assert (q1.size() > 0) else begin
                errors++; $error("FAIL w1_unexpected observed=(%0d,%h) expected=none", wa1, wd1);
            end
            if (q1.size() > 0) begin
                m1 = q1.pop_front();
                checks++;
                assert ({wa1, wd1} === {m1.addr, m1.data[11:0]}) else begin
                    errors++; $error("FAIL w1_write observed=(%0d,%h) expected=(%0d,%h)",
                                     wa1, wd1, m1.addr, m1.data[11:0]);
                end
            end
            last_we1 = cyc;
        end
        we1_prev = we1;
    end

    function automatic logic rdy(input int which);
        return (which == 0) ? r0 : r1;
    endfunction

    task automatic drive(input int which, input logic v, input logic [7:0] b);
        if (which == 0) begin
            v0 = v; d0 = b;
        end else begin
            v1 = v; d1 = b;
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input int which, input logic [7:0] b, input int gaps);
        int n;
        int guard;
        if (gaps != 0) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                drive(which, 1'b0, 8'h00);
                @(negedge clk);
            end
        end
        drive(which, 1'b1, b);
        guard = 0;
        while (rdy(which) !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        assert (guard < 100) else begin
            errors++; $error("FAIL ready_timeout observed=%0d expected<100", guard);
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input int which, input logic exp_err);
        int guard;
        guard = 0;
        while (((which == 0) ? done0 : done1) !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        assert (guard < 200) else begin
            errors++; $error("FAIL done_timeout observed=%0d expected<200", guard);
        end
        checks++;
        assert (((which == 0) ? q0.size() : q1.size()) == 0) else begin
            errors++; $error("FAIL writes_missing observed=%0d expected=0",
                             (which == 0) ? q0.size() : q1.size());
        end
        checks++;
        assert (((which == 0) ? busy0 : busy1) === 1'b0) else begin
            errors++; $error("FAIL busy_at_done observed=1 expected=0");
        end
        checks++;
        assert (rdy(which) === 1'b1) else begin
            errors++; $error("FAIL ready_at_done observed=%b expected=1", rdy(which));
        end
`ifndef LOADER_CHECKSUM_EN
        checks++;
        assert (cyc == ((which == 0) ? last_we0 : last_we1) + 2) else begin
            errors++; $error("FAIL done_latency observed=%0d expected=%0d",
                             cyc, ((which == 0) ? last_we0 : last_we1) + 2);
        end
`endif
        checks++;
        assert (((which == 0) ? err0 : err1) === exp_err) else begin
            errors++; $error("FAIL err_at_done observed=%b expected=%b",
                             (which == 0) ? err0 : err1, exp_err);
        end
        @(negedge clk);
        checks++;
        assert (((which == 0) ? done0 : done1) === 1'b0) else begin
            errors++; $error("FAIL done_pulse_width observed=1 expected=0");
        end
    endtask

    // Sends stim (address, count, data bytes) plus the checksum byte when that
    // feature is built in, after pushing the expected writes.
    task automatic send_frame(input int which, input int gaps, input logic [7:0] cs_flip);
        exp_t       e;
        logic [7:0] cs;
        for (int w = 0; w <= int'(stim[1]); w++) begin
            e.addr = stim[0][3:0] + 4'(w);
            if (which == 0) begin
                e.data = {24'h0, stim[2 + w]};
                q0.push_back(e);
            end else begin
                e.data = {20'h0, stim[3 + 2*w][3:0], stim[2 + 2*w]};
                q1.push_back(e);
            end
        end
        cs = 8'h00;
        foreach (stim[i]) begin
            send_byte(which, stim[i], gaps);
            cs = cs ^ stim[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(which, cs ^ cs_flip, gaps);
`endif
        drive(which, 1'b0, 8'h00);
        wait_done(which, cs_flip != 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        v0 = 1'b0; d0 = 8'h00;
        v1 = 1'b0; d1 = 8'h00;
        repeat (3) @(negedge clk);

        checks++;
        assert ({we0, wa0, wd0, done0, err0, busy0, r0} === {1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) else begin
            errors++; $error("FAIL reset_dut0 observed=%b expected=%b",
                             {we0, wa0, wd0, done0, err0, busy0, r0},
                             {1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        checks++;
        assert ({we1, wa1, wd1, done1, busy1} === {1'b0, 4'h0, 12'h000, 1'b0, 1'b0}) else begin
            errors++; $error("FAIL reset_dut1 observed=%b expected=0", {we1, wa1, wd1, done1, busy1});
        end

        rst_n = 1'b1;
        @(negedge clk);

        // Basic three-word frame
        stim = '{8'h03, 8'h02, 8'hA1, 8'hB2, 8'hC3};
        send_frame(0, 0, 8'h00);

        // Address wrap 14, 15, 0
        stim = '{8'h0E, 8'h02, 8'h11, 8'h22, 8'h33};
        send_frame(0, 0, 8'h00);

        // 12-bit words: high nibble of the last byte dropped
        stim = '{8'h00, 8'h00, 8'hCD, 8'hFB};
        send_frame(1, 0, 8'h00);

        // Same basic frame with random gaps in in_valid
        stim = '{8'h03, 8'h02, 8'hA1, 8'hB2, 8'hC3};
        send_frame(0, 1, 8'h00);

        // Two 12-bit words with gaps; upper address bits of the address byte ignored
        stim = '{8'hF7, 8'h01, 8'h34, 8'h12, 8'hFF, 8'hFF};
        send_frame(1, 1, 8'h00);

        // Reset mid-frame: the first data byte meets reset and must never write
        send_byte(0, 8'h05, 0);
        send_byte(0, 8'h01, 0);
        drive(0, 1'b1, 8'h77);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        drive(0, 1'b0, 8'h00);
        checks++;
        assert ({we0, busy0, r0, done0} === {1'b0, 1'b0, 1'b1, 1'b0}) else begin
            errors++; $error("FAIL reset_midframe observed=%b expected=0010", {we0, busy0, r0, done0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        stim = '{8'h01, 8'h00, 8'h99};
        send_frame(0, 0, 8'h00);

`ifdef LOADER_CHECKSUM_EN
        // Good checksum, then a bad one, then err cleared by the next address byte
        stim = '{8'h02, 8'h00, 8'h5A};
        send_frame(0, 0, 8'h00);
        send_frame(0, 0, 8'h58);
        e.addr = 4'h2;
        e.data = 32'h0000_005A;
        q0.push_back(e);
        send_byte(0, 8'h02, 0);
        checks++;
        assert (err0 === 1'b0) else begin
            errors++; $error("FAIL err_clear observed=%b expected=0", err0);
        end
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h5A, 0);
        send_byte(0, 8'h58, 0);
        drive(0, 1'b0, 8'h00);
        wait_done(0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
